// File: rtl/pulse_shaping_tx.sv
// BPSK pulse-shaping transmitter: zero-stuffs one bipolar symbol per OSR clocks into an NTAPS-tap FIR.
// Build option: define PULSE_SHAPING_TX_SAT_EN to saturate the output instead of wrapping it.

module pulse_shaping_tx #(
    parameter int unsigned NTAPS  = 31,
    parameter int unsigned OSR    = 3,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned ACC_W  = 21,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sym_valid,
    input  logic                         sym_bit,
    output logic                         sym_ready,
    input  logic                         coef_we,
    input  logic [$clog2(NTAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]     coef_data,
    output logic signed [OUT_W-1:0]      samp_out,
    output logic                         samp_valid,
    output logic                         underrun,
    output logic                         busy
);

    localparam int unsigned AW   = $clog2(NTAPS);
    localparam int unsigned PH_W = $clog2(OSR);

    localparam logic [AW-1:0]   LAST_TAP = AW'(NTAPS - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

`ifdef PULSE_SHAPING_TX_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif

    logic [1:0]               state;
    logic [1:0]               state_nx;
    logic [PH_W-1:0]          phase;
    logic [PH_W-1:0]          phase_nx;
    logic [PH_W-1:0]          phase_inc;
    logic                     accept;
    logic                     shift_en;
    logic                     underrun_set;
    logic                     tail_zero;

    // Delay line: d_nz marks a symbol present, d_neg marks it as -1.
    logic [NTAPS-1:0]         d_nz;
    logic [NTAPS-1:0]         d_neg;
    logic signed [COEF_W-1:0] coef [NTAPS];

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [OUT_W-1:0]  samp_nx;

    // Handshake and helper terms derived from the current state.
    always_comb begin
        sym_ready = (state == S_IDLE) || (phase == '0);
        accept    = sym_valid && sym_ready;
        phase_inc = (phase == PH_LAST) ? '0 : phase + PH_ONE;
        tail_zero = (d_nz[NTAPS-2:0] == '0);
    end

    // Next-state logic.
    always_comb begin
        state_nx     = state;
        phase_nx     = phase;
        shift_en     = 1'b0;
        underrun_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_RUN;
                    phase_nx = PH_ONE;
                    shift_en = 1'b1;
                end
            end
            S_RUN: begin
                shift_en = 1'b1;
                phase_nx = phase_inc;
                if (accept) begin
                    phase_nx = PH_ONE;
                end else if (phase == '0) begin
                    state_nx     = S_FLUSH;
                    underrun_set = 1'b1;
                end
            end
            S_FLUSH: begin
                shift_en = 1'b1;
                phase_nx = phase_inc;
                if (accept) begin
                    state_nx = S_RUN;
                    phase_nx = PH_ONE;
                end else if (tail_zero) begin
                    state_nx = S_IDLE;
                    phase_nx = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            phase <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // Accepted symbol enters tap 0; every other shifting edge stuffs a zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_nz  <= '0;
            d_neg <= '0;
        end else if (shift_en) begin
            d_nz  <= {d_nz[NTAPS-2:0], accept};
            d_neg <= {d_neg[NTAPS-2:0], accept & ~sym_bit};
        end
    end

    // Coefficients are only writable while idle so a running burst sees one consistent filter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                coef[k] <= '0;
            end
        end else if ((state == S_IDLE) && coef_we && (coef_addr <= LAST_TAP)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Taps are {0,+1,-1}, so the FIR reduces to conditional add/subtract.
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (d_nz[k]) begin
                if (d_neg[k]) begin
                    acc = acc - ACC_W'(coef[k]);
                end else begin
                    acc = acc + ACC_W'(coef[k]);
                end
            end
        end
    end

    always_comb begin
        acc_sh = acc >>> SHIFT;
`ifdef PULSE_SHAPING_TX_SAT_EN
        if (acc_sh > SAT_HI) begin
            samp_nx = OUT_W'(SAT_HI);
        end else if (acc_sh < SAT_LO) begin
            samp_nx = OUT_W'(SAT_LO);
        end else begin
            samp_nx = OUT_W'(acc_sh);
        end
`else
        samp_nx = OUT_W'(acc_sh);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_out   <= '0;
            samp_valid <= 1'b0;
            underrun   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            samp_out   <= samp_nx;
            samp_valid <= (state != S_IDLE);
            underrun   <= underrun | underrun_set;
            busy       <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: doc/pulse_shaping_tx.md
Name: pulse_shaping_tx

Overview:
Parametrised BPSK pulse-shaping transmitter. It accepts one bipolar symbol per OSR clocks over a valid/ready handshake, zero-stuffs the symbols up to the sample rate, and filters them through an NTAPS-tap FIR with run-time loadable coefficients. It drives one signed sample per clock to the DAC/channel path and flushes the delay line cleanly when the symbol stream stops.

Parameters:
- NTAPS, 31: FIR length; must be >= 2.
- OSR, 3: samples per symbol (upsampling factor); must be >= 2.
- COEF_W, 16: signed coefficient width.
- OUT_W, 16: signed output sample width.
- ACC_W, 21: accumulator width; must be >= COEF_W + clog2(NTAPS).
- SHIFT, 0: arithmetic right shift applied to the accumulator before the output width is reduced.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- sym_valid  in  1  symbol available.
- sym_bit  in  1  symbol value: 1 maps to +1, 0 maps to -1.
- sym_ready  out  1  the block takes a symbol this cycle.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NTAPS)  index of the tap to write.
- coef_data  in  COEF_W  signed coefficient value.
- samp_out  out  OUT_W  signed shaped sample.
- samp_valid  out  1  samp_out is valid.
- underrun  out  1  sticky flag: the stream stopped while RUN.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous) clears the following immediately:
  - state goes to IDLE; phase=0.
  - delay line is all zero; all coefficients are 0.
  - samp_out=0, samp_valid=0, underrun=0, busy=0.
  - sym_ready=1 once reset is released.
  - Reset mid-stream aborts the stream with no flush.
- Delay line: NTAPS entries, each holding one of {0,+1,-1}. It shifts every clock in RUN and FLUSH; it holds in IDLE.
- Accept: a symbol is taken when sym_valid and sym_ready are both 1 on a clock edge.
  - The accepted symbol enters tap 0 on that edge.
  - Non-accept edges in RUN and FLUSH shift a 0 into tap 0 (zero-stuffing).
- sym_ready is 1 in IDLE, and in RUN/FLUSH only when phase==0. It is combinational from state and phase.
- phase counter: counts 0..OSR-1 and wraps to 0. It advances every clock in RUN and FLUSH. Acceptance forces the next phase to 1.
- Output: acc = sum over k of d[k]*coef[k], computed as add/subtract only (no multipliers).
  - samp_out <= acc >>> SHIFT, reduced to OUT_W bits.
  - samp_out is registered: it reflects the delay line as it stands after the previous edge, so latency is 1 clock from acceptance to that symbol's first contribution.
- samp_valid is 1 on every clock in which samp_out was computed in RUN/FLUSH. It falls 1 clock after entering IDLE.
- Width rule: samp_out is reduced to OUT_W by truncation to the low bits (wrap), unless the optional feature below is enabled.
- FSM transitions:
  - IDLE: on accept, go to RUN.
  - RUN: at phase==0 with sym_valid=0, go to FLUSH and set underrun.
  - FLUSH: on accept at phase==0, return to RUN; otherwise go to IDLE on the first edge after which the delay line is all zero.
  - A single symbol therefore occupies NTAPS output samples, after which the block returns to IDLE.
- Coefficient writes take effect only in IDLE, at the edge where coef_we=1. Writes in RUN/FLUSH are ignored. A write and an accept on the same IDLE edge both take effect.
- underrun is cleared only by reset.

Optional Feature:
- Macro name: PULSE_SHAPING_TX_SAT_EN.
- Defined: the shifted accumulator saturates to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the result wraps by keeping the low OUT_W bits. No saturation logic is generated.

Test Plan:
1. Load coef[k]=k+1 (k=0..30), send a single symbol bit=1 -> samp_out=1,2,...,31 on 31 consecutive valid cycles; then samp_valid=0, busy=0, underrun=1.
2. Same coefficients, single symbol bit=0 -> samp_out=-1,-2,...,-31; back in IDLE after 31 samples.
3. Same coefficients, stream +1,-1 back-to-back with sym_valid held -> sym_ready pulses every 3rd clock; the 4th sample is coef[3]-coef[0]=4-1=3; underrun stays 0 while the stream continues.
4. All coef=0x7FFF, 11 consecutive +1 symbols -> steady state sum is 360437. With PULSE_SHAPING_TX_SAT_EN the output is 32767; without it the output is 0x7FF5 (32757).
5. Write coef[0]=5 during RUN -> write ignored, output unchanged. Repeat the write in IDLE and send +1 -> first sample is 5.
6. Pull reset low mid-RUN -> the same cycle shows samp_out=0, samp_valid=0, busy=0, underrun=0. After release, sym_ready=1; with no coefficient reload, sending +1 gives samp_out=0 for 31 cycles.
